// File: rtl/imem_loader.sv
// Purpose: boot loader that streams a framed byte sequence into the 64-word instruction memory.
// Latency: one write strobe the cycle after each word's 4th byte; status changes the cycle after the checksum byte.
// Backpressure: byte_ready_o comes only from the registered state (HDR/DATA/CSUM) and sustains one byte per cycle.
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk_i,
    input  logic          reset_i,        // asynchronous, active-low
    input  logic          start_i,
    input  logic          byte_valid_i,
    input  logic [7:0]    byte_data_i,
    output logic          byte_ready_o,
    output logic          we_o,
    output logic [AW-1:0] waddr_o,
    output logic [31:0]   wdata_o,
    output logic          cpu_reset_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          error_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);
    localparam logic [AW:0] ONE    = (AW+1)'(1);

    state_t        state_q;
    logic [AW:0]   n_q;        // word count of the current frame, 1..DEPTH
    logic [AW-1:0] addr_q;     // index of the word being assembled
    logic [1:0]    bidx_q;     // byte lane of the next data byte
    logic [23:0]   lanes_q;    // lanes 0..2 of the word being assembled
    logic [7:0]    xor_q;      // running XOR of the data bytes
    logic          we_q;
    logic [AW-1:0] waddr_q;
    logic [31:0]   wdata_q;

    logic          xfer;
    logic          hdr_ok;
    logic          last_word;
    logic [31:0]   word_d;

    assign xfer      = byte_valid_i && byte_ready_o;
    assign hdr_ok    = (byte_data_i != 8'd0) && (byte_data_i <= DEPTH_B);
    assign last_word = ({1'b0, addr_q} == (n_q - ONE));
    // The 4th byte goes to lane 3, so the completed word is the incoming byte over the stored lanes.
    assign word_d    = {byte_data_i, lanes_q};

    // Session FSM together with word assembly, checksum and the registered write port.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            addr_q  <= '0;
            bidx_q  <= '0;
            lanes_q <= '0;
            xor_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= 1'b0;
            if (start_i) begin
                // Start (re)opens a session from any state; a byte in the same cycle is dropped.
                state_q <= S_HDR;
                addr_q  <= '0;
                bidx_q  <= '0;
                lanes_q <= '0;
                xor_q   <= '0;
            end else begin
                case (state_q)
                    S_HDR: begin
                        if (xfer) begin
                            if (hdr_ok) begin
                                n_q     <= byte_data_i[AW:0];
                                addr_q  <= '0;
                                bidx_q  <= '0;
                                lanes_q <= '0;
                                xor_q   <= '0;
                                state_q <= S_DATA;
                            end else begin
                                state_q <= S_ERR;
                            end
                        end
                    end
                    S_DATA: begin
                        if (xfer) begin
                            xor_q <= xor_q ^ byte_data_i;
                            if (bidx_q == 2'd3) begin
                                we_q    <= 1'b1;
                                waddr_q <= addr_q;
                                wdata_q <= word_d;
                                bidx_q  <= 2'd0;
                                // Hold the address on the last word so it never wraps past DEPTH-1.
                                if (last_word) begin
                                    state_q <= S_CSUM;
                                end else begin
                                    addr_q <= addr_q + 1'b1;
                                end
                            end else begin
                                case (bidx_q)
                                    2'd0:    lanes_q[7:0]   <= byte_data_i;
                                    2'd1:    lanes_q[15:8]  <= byte_data_i;
                                    default: lanes_q[23:16] <= byte_data_i;
                                endcase
                                bidx_q <= bidx_q + 1'b1;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (xfer) begin
                            state_q <= (byte_data_i == xor_q) ? S_DONE : S_ERR;
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign byte_ready_o = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign busy_o       = byte_ready_o;
    assign done_o       = (state_q == S_DONE);
    assign error_o      = (state_q == S_ERR);
    assign cpu_reset_o  = (state_q != S_DONE);
    assign we_o         = we_q;
    assign waddr_o      = waddr_q;
    assign wdata_o      = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Purpose: randomized scoreboard bench for imem_loader against a frame-level reference model.
// Latency: expects each write the cycle after a word's 4th byte and status the cycle after the last byte.
// Backpressure: the driver waits (bounded) on byte_ready_o before completing each byte.
module tb_imem_loader;

    typedef logic [7:0] frame_t[$];

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [37:0] exp_q[$];   // {addr, data} of expected writes, in order
    logic        exp_done;
    logic        exp_err;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(64), .AW(6)) dut (
        .clk_i        (clk),
        .reset_i      (reset_n),
        .start_i      (start),
        .byte_valid_i (byte_valid),
        .byte_data_i  (byte_data),
        .byte_ready_o (byte_ready),
        .we_o         (we),
        .waddr_o      (waddr),
        .wdata_o      (wdata),
        .cpu_reset_o  (cpu_reset),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected-write queue.
    always @(negedge clk) begin
        logic [37:0] e;
        if (reset_n && we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %08h, expected no write", waddr, wdata);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", 64'(waddr), 64'(e[37:32]));
                chk("write_data", 64'(wdata), 64'(e[31:0]));
            end
        end
    end

    // Reference model: decode a whole frame into its writes and final status.
    task automatic model_frame(input frame_t f);
        int n;
        logic [7:0] x;
        n = int'(f[0]);
        if (n == 0 || n > 64) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        x = 8'h00;
        for (int w = 0; w < n; w++) begin
            exp_q.push_back({6'(w), f[4*w+4], f[4*w+3], f[4*w+2], f[4*w+1]});
        end
        for (int i = 1; i <= 4*n; i++) x = x ^ f[i];
        exp_done = (f[4*n+1] == x);
        exp_err  = !exp_done;
    endtask

    function automatic frame_t make_frame(input int n, input bit good);
        frame_t f;
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        f.push_back(8'(n));
        for (int i = 0; i < 4*n; i++) begin
            b = 8'($urandom_range(255, 0));
            f.push_back(b);
            x = x ^ b;
        end
        f.push_back(good ? x : (x ^ 8'($urandom_range(255, 1))));
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int mingap, input int maxgap);
        int g;
        int t;
        g = $urandom_range(maxgap, mingap);
        t = 0;
        @(negedge clk);
        repeat (g) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got byte_ready 0 for %0d cycles, expected 1", t);
            byte_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("ready_after_start", 64'(byte_ready), 64'd1);
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_done"}, 64'(done), 64'(exp_done));
        chk({tag, "_error"}, 64'(error), 64'(exp_err));
        chk({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(!exp_done));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #1 chk({tag, "_writes_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic send_frame(input frame_t f, input int mingap, input int maxgap);
        int n;
        n = int'(f[0]);
        if (n == 0 || n > 64) begin
            send_byte(f[0], mingap, maxgap);
        end else begin
            foreach (f[i]) send_byte(f[i], mingap, maxgap);
        end
    endtask

    task automatic run_frame(input string tag, input frame_t f, input int mingap, input int maxgap);
        model_frame(f);
        pulse_start();
        send_frame(f, mingap, maxgap);
        check_status(tag);
    endtask

    initial begin
        frame_t nom;
        frame_t f;
        nom = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
        reset_n    = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #1;
        chk("rst_byte_ready", 64'(byte_ready), 64'd0);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_waddr", 64'(waddr), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1 chk("idle_cpu_reset", 64'(cpu_reset), 64'd1);

        run_frame("nominal", nom, 0, 0);
        run_frame("hdr00", '{8'h00}, 0, 0);
        run_frame("hdr41", '{8'h41}, 0, 0);
        run_frame("full64", make_frame(64, 1'b1), 0, 0);
        f = nom;
        f[9] = 8'hFF;
        run_frame("bad_csum", f, 0, 0);
        run_frame("gapped", nom, 1, 3);

        // Abort after two data bytes, with a byte offered in the start cycle.
        pulse_start();
        send_byte(8'h02, 0, 0);
        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 0, 0);
        @(negedge clk);
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h33;
        @(posedge clk);
        #1;
        start      = 1'b0;
        byte_valid = 1'b0;
        chk("abort_ready", 64'(byte_ready), 64'd1);
        f = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        model_frame(f);
        send_frame(f, 0, 1);
        check_status("abort");

        // Reset asserted after six data bytes: only word 0 may have been written.
        exp_q.push_back({6'd0, 32'h04030201});
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(nom[i], 0, 0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_byte_ready", 64'(byte_ready), 64'd0);
        chk("midrst_we", 64'(we), 64'd0);
        chk("midrst_waddr", 64'(waddr), 64'd0);
        chk("midrst_wdata", 64'(wdata), 64'd0);
        chk("midrst_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_error", 64'(error), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("midrst_hold_we", 64'(we), 64'd0);
        end
        reset_n = 1'b1;
        chk("midrst_queue", 64'(exp_q.size()), 64'd0);
        run_frame("after_rst", nom, 0, 0);

        // Random frames, including occasional illegal headers and bad checksums.
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(7, 0) == 0) begin
                f = '{8'($urandom_range(255, 65))};
            end else begin
                f = make_frame(int'($urandom_range(8, 1)), $urandom_range(3, 0) != 0);
            end
            run_frame("random", f, 0, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Sequential boot loader for the 64-word instruction memory of the single-cycle ARM processor. It accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and drives the memory's write port one word at a time. It verifies a checksum and holds the processor in reset until a load completes successfully.

## Interface
- `DEPTH`, 64: number of instruction words; the maximum legal frame length.
- `AW`, 6: word-address width; must satisfy 2^AW = DEPTH.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `start`  in  1  one-cycle pulse that begins (or restarts) a load session.
- `byte_valid`  in  1  the source has a byte on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  the loader accepts a byte this cycle.
- `we`  out  1  instruction-memory write strobe, one cycle per word.
- `waddr`  out  AW  word address (word index, not byte address).
- `wdata`  out  32  word to write.
- `cpu_reset`  out  1  active-high reset to the processor.
- `busy`  out  1  a session is in progress (states HDR, DATA, CSUM).
- `done`  out  1  the last session succeeded.
- `error`  out  1  the last session failed.

## Operation
- Frame format: header byte N (word count), then 4·N data bytes (least-significant byte of each word first), then one checksum byte equal to the XOR of all 4·N data bytes.
- A transfer occurs on any cycle with `byte_valid && byte_ready`.
- States: IDLE, HDR, DATA, CSUM, DONE, ERR.
- IDLE: `start` moves to HDR. `cpu_reset` is held at 1.
- HDR: on a transfer, N=0 or N>DEPTH moves to ERR. Otherwise it latches N, clears the word address, byte index (0..3) and running XOR, and moves to DATA.
- DATA: each transfer shifts the byte into lane `byte index` and XORs it into the running checksum.
  - On the 4th byte the loader issues a write for the current address, increments the address and resets the byte index.
  - After the 4th byte of word N-1 it moves to CSUM.
- CSUM: on a transfer, a match with the running XOR moves to DONE. A mismatch moves to ERR. Words already written stay written.
- DONE: `done`=1, `cpu_reset`=0. `start` moves to HDR.
- ERR: `error`=1, `cpu_reset`=1. `start` moves to HDR.
- `start` in HDR/DATA/CSUM aborts the session and moves to HDR with counters cleared. A byte transferred in the same cycle is discarded. Partially loaded words are never written.
- `cpu_reset` is 1 in every state except DONE.
- Memory locations at addresses ≥ N are never written. `waddr` never wraps; the maximum is DEPTH-1.

## Timing
- Reset values: `byte_ready`=0, `we`=0, `waddr`=0, `wdata`=0, `cpu_reset`=1, `busy`=0, `done`=0, `error`=0, state IDLE.
- `byte_ready` is a decode of the registered state only: 1 in HDR, DATA and CSUM. It has no combinational path from `byte_valid`. The loader sustains one byte per cycle.
- `start` to HDR: 1 cycle. `byte_ready` rises the cycle after `start`.
- Write latency: `we`, `waddr` and `wdata` are registered. They are valid for exactly one cycle, the cycle after the 4th byte's transfer. `we` is 0 otherwise.
- `done`/`error`/`cpu_reset` update the cycle after the checksum transfer, or the cycle after an illegal header.
- `busy` is 1 exactly while the state is HDR, DATA or CSUM.
- When `reset` is asserted mid-session, all outputs take their reset values asynchronously and any pending write is dropped.

## Test plan
- Nominal: `start`, then bytes 02, 01 02 03 04, 05 06 07 08, checksum 08 -> `we` pulses: addr 0 data 0x04030201, then addr 1 data 0x08070605; `done`=1 and `cpu_reset`=0 one cycle after the checksum byte.
- Header 0x00, and separately header 0x41 (65) -> `error`=1, no `we`, `cpu_reset`=1. Header 0x40 with 256 bytes and correct XOR -> last write at addr 63, `done`=1.
- Nominal frame with checksum 0xFF -> both writes occur, `error`=1, `done`=0, `cpu_reset`=1.
- `byte_valid` toggled every other cycle with random gaps -> write data, addresses and final status identical to the nominal case.
- `start` re-pulsed after 2 data bytes (with a byte valid in the same cycle), then frame 01, AA BB CC DD, checksum 0x00 -> single write at addr 0 data 0xDDCCBBAA, `done`=1.
- `reset` asserted low after 6 data bytes -> outputs at reset values in the same cycle, no further `we`. After release, a nominal frame loads correctly.
